// File: rtl/jtframe_ram_loader.sv
// jtframe_ram_loader: sits in front of a clock-enabled RAM write port.
// After reset it fills the RAM with CLR_VAL, while a download is active it
// copies download bytes that land in the address window into the RAM, and
// otherwise it hands the port straight to the CPU.
module jtframe_ram_loader #(
  parameter int          dw      = 8,
  parameter int          aw      = 10,
  parameter logic [21:0] START   = 22'd0,
  parameter logic [dw-1:0] CLR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          downloading,
  input  logic [21:0]   ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  input  logic [aw-1:0] cpu_addr,
  input  logic [dw-1:0] cpu_din,
  input  logic          cpu_we,
  output logic [aw-1:0] ram_addr,
  output logic [dw-1:0] ram_data,
  output logic          ram_we,
  output logic          ram_cen,
  output logic          busy
);

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

  // Window size in download bytes: one byte per word for dw=8, two for dw=16.
  localparam logic [31:0]   WIN_SIZE = 32'((2 ** aw) * (dw / 8));
  localparam logic [aw-1:0] CNT_LAST = '1;

  state_t        state_reg, state_next;
  logic [aw-1:0] cnt_reg,   cnt_next;
  logic [aw-1:0] addr_reg,  addr_next;
  logic [dw-1:0] data_reg,  data_next;
  logic          we_reg,    we_next;
  logic [7:0]    latch_reg, latch_next;

  logic [21:0]   offset;
  logic          in_window;
  logic [aw-1:0] load_addr;
  logic [dw-1:0] load_data;
  logic          load_fire;
  logic          pass;

  assign offset    = ioctl_addr - START;
  assign in_window = (ioctl_addr >= START) && ({10'd0, offset} < WIN_SIZE);

  // Byte-to-word mapping: 16-bit RAMs pack bytes little-endian and only
  // write on the odd byte, using the latched even byte as the low half.
  generate
    if (dw == 16) begin : g_w16
      assign load_addr = offset[aw:1];
      assign load_data = {ioctl_data, latch_reg};
      assign load_fire = offset[0];
    end else begin : g_w8
      assign load_addr = offset[aw-1:0];
      assign load_data = ioctl_data;
      assign load_fire = 1'b1;
    end
  endgenerate

  // State and write-port registers; reset aborts any clear or download.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      we_reg    <= 1'b0;
      latch_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      we_reg    <= we_next;
      latch_reg <= latch_next;
    end
  end

  // Next-state logic; the write strobe defaults low so it lasts one clk.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    we_next    = 1'b0;
    latch_next = latch_reg;
    case (state_reg)
      CLEAR: begin
        addr_next = cnt_reg;
        data_next = CLR_VAL;
        we_next   = 1'b1;
        // End test happens before the increment so the counter never wraps.
        if (cnt_reg == CNT_LAST) state_next = RUN;
        else                     cnt_next   = cnt_reg + 1'b1;
        if (downloading) begin
          state_next = LOAD;
          latch_next = '0;
        end
      end
      LOAD: begin
        if (ioctl_wr && in_window) begin
          if (load_fire) begin
            addr_next = load_addr;
            data_next = load_data;
            we_next   = 1'b1;
          end else begin
            latch_next = ioctl_data;
          end
        end
        if (!downloading) state_next = RUN;
      end
      RUN: begin
        if (downloading) begin
          state_next = LOAD;
          latch_next = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // A write registered on the edge that enters RUN is still shown for its
  // clk before the port is handed to the CPU.
  assign pass     = (state_reg == RUN) && !we_reg;
  assign ram_addr = pass ? cpu_addr : addr_reg;
  assign ram_data = pass ? cpu_din  : data_reg;
  assign ram_we   = pass ? cpu_we   : we_reg;
  assign ram_cen  = pass ? cen      : 1'b1;
  assign busy     = !pass;

endmodule

// File: doc/jtframe_ram_loader.md
Name: jtframe_ram_loader

Overview:
- Sits directly upstream of the generic clock-enabled RAM and drives its clk-domain write port: addr, data, we, cen.
- After reset it clears every RAM word to a fixed value.
- While a ROM/RAM download is active, it writes download bytes that fall inside a parameterised address window into the RAM.
- Otherwise it passes CPU accesses straight through to the RAM.

Parameters:
- dw, 8: RAM data width; only 8 or 16 are legal (16 = little-endian byte packing).
- aw, 10: RAM address width.
- START, 0: first download byte address mapped to RAM word 0 (22-bit value).
- CLR_VAL, 0: value written to every word during clear (dw bits).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cen  input  1  CPU-side clock enable, forwarded to the RAM in RUN.
- downloading  input  1  download in progress.
- ioctl_addr  input  22  download byte address.
- ioctl_data  input  8  download byte.
- ioctl_wr  input  1  one-clk strobe, download byte valid.
- cpu_addr  input  aw  CPU word address.
- cpu_din  input  dw  CPU write data.
- cpu_we  input  1  CPU write request.
- ram_addr  output  aw  to RAM addr.
- ram_data  output  dw  to RAM data.
- ram_we  output  1  to RAM we.
- ram_cen  output  1  to RAM cen.
- busy  output  1  high in CLEAR and LOAD; CPU writes are dropped.

Behaviour:
- States: CLEAR, LOAD, RUN. Async reset forces CLEAR with:
  - clear counter = 0;
  - internal ram_addr/ram_data/ram_we registers = 0;
  - byte latch = 0;
  - busy = 1.
  - Reset asserted mid-operation aborts everything immediately; clear restarts from word 0 after release.
- CLEAR:
  - Each clk: ram_addr = counter, ram_data = CLR_VAL, ram_we = 1, ram_cen = 1; counter increments by 1, independent of cen.
  - At counter = 2^aw-1, that word is written and the next state is RUN (or LOAD if downloading = 1). Clearing takes exactly 2^aw clks.
  - downloading = 1 at any point pre-empts CLEAR: next clk enters LOAD. The clear is not resumed.
- LOAD (entered from any state while downloading = 1):
  - ram_cen = 1. The byte latch is zeroed on entry.
  - Window offset = ioctl_addr - START, 22-bit unsigned. A byte is in-window iff START <= ioctl_addr and offset < 2^aw*(dw/8). Out-of-window strobes are ignored.
  - dw = 8: on an in-window ioctl_wr, the next clk presents ram_addr = offset[aw-1:0], ram_data = ioctl_data, ram_we = 1, for exactly one clk.
  - dw = 16, offset[0] = 0: latch the byte as the low byte; no write.
  - dw = 16, offset[0] = 1: next clk presents ram_addr = offset[aw:1], ram_data = {ioctl_data, latch}, ram_we = 1, for one clk. A lone odd byte writes the current latch contents as the low byte.
  - Write latency: 1 clk after ioctl_wr. Back-to-back strobes on consecutive clks must each produce a write.
  - downloading falling → RUN on the next clk. A write already scheduled on that edge still completes.
- RUN:
  - Combinational pass-through: ram_addr = cpu_addr, ram_data = cpu_din, ram_we = cpu_we, ram_cen = cen. Zero added latency. busy = 0.
- In CLEAR and LOAD, cpu_we is ignored and never reaches the RAM.
- ram_we is never high for more than one clk per download write. In CLEAR it is high every clk.
- The counter does not wrap: the end condition is compared before incrementing.

Test Plan:
- aw=4, dw=8, CLR_VAL=8'hA5: release reset with downloading = 0 → ram_we high for exactly 16 clks, addresses 0..15, data A5, then RUN with busy = 0; reading any address returns A5.
- dw=8, START=22'h400: strobe ioctl_addr 0x3FF, 0x400, 0x7FF (aw=10), 0x800 with data 11, 22, 33, 44 → exactly two writes: addr 0 = 22 and addr 1023 = 33, each one clk after its strobe.
- dw=16, START=0: bytes 0x34 @0, 0x12 @1, then a lone 0xCD @3 → writes: word 0 = 16'h1234 after the second strobe; word 1 = 16'hCD34 (stale latch), no write on even strobes.
- aw=10, default CLR_VAL: assert downloading at clear counter = 5 → LOAD next clk; clearing stops; words 6..1023 keep prior contents; busy stays 1 until downloading falls, then RUN next clk.
- RUN: cpu_we = 1, cen toggling, cpu_addr = 3, cpu_din = 5A → ram_* follow the CPU inputs the same cycle; ram_cen = cen. In LOAD the same stimulus gives ram_we = 0.
- Assert rst asynchronously mid-LOAD between clk edges → busy = 1 and ram_we = 0 immediately; after release, a full 2^aw-clk clear from word 0 occurs.
